hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Consumer of the main-control pipeline outputs for the 5-stage MIPS core.
- Takes regwrite/memtoreg/branch/jr flags and register numbers from D/E/M/W.
- Returns stall/flush to the fetch/decode registers and to the E-stage control register (stallE, flushE), plus forwarding selects for the D-stage comparator and E-stage ALU.
- Also sequences the multi-cycle divider occupancy of E.

Parameters:
DIV_CYCLES, 32, E-stage occupancy of a div/divu in cycles; legal range 1..255
CNT_W, 8, width of the divider countdown counter; must hold DIV_CYCLES-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
rsD  in  5  D-stage rs
rtD  in  5  D-stage rt
branchD  in  1  D-stage conditional branch (compared in D)
jrD  in  1  D-stage jr/jalr (rs read in D)
rsE  in  5  E-stage rs
rtE  in  5  E-stage rt
writeregE  in  5  E-stage destination register
regwriteE  in  1  E-stage register write
memtoregE  in  1  E-stage load
divE  in  1  E-stage div/divu
writeregM  in  5  M-stage destination
regwriteM  in  1  M-stage register write
memtoregM  in  1  M-stage load
writeregW  in  5  W-stage destination
regwriteW  in  1  W-stage register write
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
flushE  out  1  clear D/E register (insert bubble)
forwardaD  out  1  D comparator operand A from M result
forwardbD  out  1  D comparator operand B from M result
forwardaE  out  2  ALU A select: 00 regfile, 01 W result, 10 M result
forwardbE  out  2  ALU B select; same encoding as forwardaE
divbusy  out  1  divider sequencer in BUSY
divdoneE  out  1  one-cycle pulse, last E cycle of a div
stallcnt  out  32  stall-cycle count (optional feature)

Behaviour:
- Register $0 never matches: any compare where the source register is 0 yields no forward and no stall.
- forwardaE = 10 if rsE!=0 & regwriteE... no: 10 if rsE!=0 & regwriteM & rsE==writeregM; else 01 if rsE!=0 & regwriteW & rsE==writeregW; else 00. M has priority over W. forwardbE is the same using rtE.
- forwardaD = rsD!=0 & regwriteM & rsD==writeregM. forwardbD is the same using rtD.
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- branchstall:
  - branchD & ((regwriteE & writeregE in {rsD,rtD}) | (memtoregM & writeregM in {rsD,rtD})).
  - OR jrD & ((regwriteE & writeregE==rsD) | (memtoregM & writeregM==rsD)).
- Divider FSM, states IDLE and BUSY; counter cnt of CNT_W bits.
  - IDLE & divE: divstall=1; next state BUSY, cnt <= DIV_CYCLES-1.
  - BUSY & cnt!=0: divstall=1; cnt <= cnt-1.
  - BUSY & cnt==0: divstall=0, divdoneE=1; next state IDLE.
  - A div therefore holds E for exactly DIV_CYCLES stalled cycles, then 1 completing cycle.
  - Back-to-back divs: the second div enters E after the completing cycle and restarts from IDLE.
- divbusy = (state==BUSY).
- stallF = stallD = lwstall | branchstall | divstall.
- stallE = divstall.
- flushE = (lwstall | branchstall) & ~divstall. Never flush a held E stage.
- All outputs above are combinational from inputs and FSM state: zero latency.
- While rst=1: every stall, flush, forward, divbusy and divdoneE output is forced to 0.
- Reset, applied at any cycle including mid-BUSY: at the clock edge the FSM goes to IDLE and cnt to 0. The pending div is abandoned.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined:
  - stallcnt is a 32-bit register, reset to 0.
  - Increments by 1 on each cycle with stallF=1 and rst=0.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: stallcnt is tied to constant 0 and no counter register exists.

Test Plan:
- Forwarding priority: regwriteM=1, writeregM=5; regwriteW=1, writeregW=5; rsE=5, rtE=0 -> forwardaE=10, forwardbE=00. Then regwriteM=0 -> forwardaE=01.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1, stallE=0. Next cycle with memtoregE=0 -> all four are 0.
- Branch hazard: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stall and flush for 1 cycle. Next cycle the producer is in M (writeregM=3, regwriteM=1, memtoregM=0) -> forwardaD=1, no stall.
- Divider, DIV_CYCLES=4, divE=1 held:
  - stallE=stallF=1 for exactly 4 cycles and flushE=0 throughout.
  - 5th cycle: divdoneE=1, stalls=0, divbusy falls 1 cycle later.
- rst=1 asserted during the 2nd BUSY cycle -> all outputs 0 during reset. After release with divE=0, divbusy=0 and a new div again gives 4 stall cycles.
- HAZARD_STALL_CNT_EN defined: 3 load-use stalls plus 1 div with DIV_CYCLES=4 -> stallcnt=7. Undefined -> stallcnt=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard detection, forwarding and divider-occupancy sequencing for the 5-stage MIPS core.
// Optional stall-cycle counter on output stallcnt is enabled by defining HAZARD_STALL_CNT_EN.
module hazard_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        branchD,
  input  logic        jrD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic        regwriteE,
  input  logic        memtoregE,
  input  logic        divE,
  input  logic [4:0]  writeregM,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic [4:0]  writeregW,
  input  logic        regwriteW,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushE,
  output logic        forwardaD,
  output logic        forwardbD,
  output logic [1:0]  forwardaE,
  output logic [1:0]  forwardbE,
  output logic        divbusy,
  output logic        divdoneE,
  output logic [31:0] stallcnt
);

  typedef enum logic {IDLE, BUSY} div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             divstall, divdone, lwstall, branchstall;

  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (regwriteM && reg_match(src, writeregM))      return 2'b10;
    else if (regwriteW && reg_match(src, writeregW)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    divstall = 1'b0;
    divdone  = 1'b0;
    case (state_q)
      IDLE: begin
        if (divE) begin
          divstall = 1'b1;
          state_d  = BUSY;
          cnt_d    = CNT_W'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          divstall = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          divdone  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lwstall = memtoregE && (reg_match(rsD, rtE) || reg_match(rtD, rtE));
    branchstall =
      (branchD && ((regwriteE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE))) ||
                   (memtoregM && (reg_match(rsD, writeregM) || reg_match(rtD, writeregM))))) ||
      (jrD && ((regwriteE && reg_match(rsD, writeregE)) ||
               (memtoregM && reg_match(rsD, writeregM))));
  end

  // Every hazard output is held inactive while reset is asserted.
  always_comb begin
    stallF    = ~rst & (lwstall | branchstall | divstall);
    stallD    = stallF;
    stallE    = ~rst & divstall;
    flushE    = ~rst & (lwstall | branchstall) & ~divstall;
    forwardaD = ~rst & regwriteM & reg_match(rsD, writeregM);
    forwardbD = ~rst & regwriteM & reg_match(rtD, writeregM);
    forwardaE = rst ? 2'b00 : fwd_sel(rsE);
    forwardbE = rst ? 2'b00 : fwd_sel(rtE);
    divbusy   = ~rst & (state_q == BUSY);
    divdoneE  = ~rst & divdone;
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stallcnt_q;

  always_ff @(posedge clk) begin
    if (rst)         stallcnt_q <= '0;
    else if (stallF) stallcnt_q <= stallcnt_q + 32'd1;
  end

  assign stallcnt = stallcnt_q;
`else
  assign stallcnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit, built with DIV_CYCLES=4.
// Stall counter expectation follows HAZARD_STALL_CNT_EN.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        branchD, jrD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW;
  logic        stallF, stallD, stallE, flushE, forwardaD, forwardbD, divbusy, divdoneE;
  logic [1:0]  forwardaE, forwardbE;
  logic [31:0] stallcnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HAZARD_STALL_CNT_EN
  localparam logic [31:0] EXP_CNT = 32'd7;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif

  hazard_unit #(.DIV_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .divE(divE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .divbusy(divbusy), .divdoneE(divdoneE), .stallcnt(stallcnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; jrD = 0; regwriteE = 0; memtoregE = 0; divE = 0;
    regwriteM = 0; memtoregM = 0; regwriteW = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    memtoregE = 1; rtE = 8; rsD = 8;
    regwriteM = 1; writeregM = 5; rsE = 5;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({stallF, stallD, stallE, flushE, forwardaD, forwardbD, forwardaE, forwardbE, divbusy, divdoneE} !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000000000",
               {stallF, stallD, stallE, flushE, forwardaD, forwardbD, forwardaE, forwardbE, divbusy, divdoneE});
    end
    n_checks++;
    if (stallcnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_stallcnt: got %0d expected 0", stallcnt);
    end
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5; rsE = 5; rtE = 0;
    @(negedge clk);
    n_checks++;
    if ({forwardaE, forwardbE} !== 4'b1000) begin
      n_fail++; $display("FAIL fwd_m_priority: got %b expected 1000", {forwardaE, forwardbE});
    end
    regwriteM = 0;
    #1;
    n_checks++;
    if ({forwardaE, forwardbE} !== 4'b0100) begin
      n_fail++; $display("FAIL fwd_w_only: got %b expected 0100", {forwardaE, forwardbE});
    end
    regwriteM = 1; writeregM = 7; rtE = 7; rsE = 9;
    #1;
    n_checks++;
    if ({forwardaE, forwardbE} !== 4'b0010) begin
      n_fail++; $display("FAIL fwd_b_from_m: got %b expected 0010", {forwardaE, forwardbE});
    end
    regwriteM = 1; writeregM = 0; regwriteW = 1; writeregW = 0; rsE = 0; rtE = 0;
    rsD = 0; rtD = 0;
    #1;
    n_checks++;
    if ({forwardaE, forwardbE, forwardaD, forwardbD} !== 6'b0) begin
      n_fail++; $display("FAIL fwd_reg0: got %b expected 000000", {forwardaE, forwardbE, forwardaD, forwardbD});
    end
    writeregM = 6; rtD = 6; rsD = 2;
    #1;
    n_checks++;
    if ({forwardaD, forwardbD} !== 2'b01) begin
      n_fail++; $display("FAIL fwd_bD: got %b expected 01", {forwardaD, forwardbD});
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    memtoregE = 1; rtE = 8; rsD = 8;
    @(negedge clk);
    n_checks++;
    if ({stallF, stallD, stallE, flushE} !== 4'b1101) begin
      n_fail++; $display("FAIL lw_stall: got %b expected 1101", {stallF, stallD, stallE, flushE});
    end
    next_cycle();
    memtoregE = 0;
    @(negedge clk);
    n_checks++;
    if ({stallF, stallD, stallE, flushE} !== 4'b0000) begin
      n_fail++; $display("FAIL lw_release: got %b expected 0000", {stallF, stallD, stallE, flushE});
    end
    memtoregE = 1; rtE = 0; rsD = 0; rtD = 0;
    #1;
    n_checks++;
    if ({stallF, flushE} !== 2'b00) begin
      n_fail++; $display("FAIL lw_reg0: got %b expected 00", {stallF, flushE});
    end
    next_cycle();
  endtask

  task automatic test_branch();
    clear_inputs();
    branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    @(negedge clk);
    n_checks++;
    if ({stallF, stallD, stallE, flushE, forwardaD} !== 5'b11010) begin
      n_fail++; $display("FAIL br_stall: got %b expected 11010", {stallF, stallD, stallE, flushE, forwardaD});
    end
    next_cycle();
    regwriteE = 0; writeregE = 0; writeregM = 3; regwriteM = 1; memtoregM = 0;
    @(negedge clk);
    n_checks++;
    if ({stallF, stallD, stallE, flushE, forwardaD} !== 5'b00001) begin
      n_fail++; $display("FAIL br_forward: got %b expected 00001", {stallF, stallD, stallE, flushE, forwardaD});
    end
    next_cycle();
    clear_inputs();
    jrD = 1; rsD = 4; rtD = 9; regwriteM = 1; memtoregM = 1; writeregM = 4;
    @(negedge clk);
    n_checks++;
    if ({stallF, stallE, flushE} !== 3'b101) begin
      n_fail++; $display("FAIL jr_load_stall: got %b expected 101", {stallF, stallE, flushE});
    end
    rsD = 2; writeregM = 9;
    #1;
    n_checks++;
    if ({stallF, flushE} !== 2'b00) begin
      n_fail++; $display("FAIL jr_ignores_rt: got %b expected 00", {stallF, flushE});
    end
    next_cycle();
  endtask

  task automatic test_divider();
    clear_inputs();
    divE = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({stallF, stallD, stallE, flushE, divdoneE, divbusy} !== {4'b1110, 1'b0, (c != 1)}) begin
        n_fail++;
        $display("FAIL div_stall_cycle%0d: got %b expected %b", c,
                 {stallF, stallD, stallE, flushE, divdoneE, divbusy}, {4'b1110, 1'b0, (c != 1)});
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if ({stallF, stallD, stallE, flushE, divdoneE, divbusy} !== 6'b000011) begin
      n_fail++; $display("FAIL div_done: got %b expected 000011", {stallF, stallD, stallE, flushE, divdoneE, divbusy});
    end
    next_cycle();
    divE = 0;
    @(negedge clk);
    n_checks++;
    if ({stallE, divdoneE, divbusy} !== 3'b000) begin
      n_fail++; $display("FAIL div_idle_after: got %b expected 000", {stallE, divdoneE, divbusy});
    end
    divE = 1; memtoregE = 1; rtE = 8; rsD = 8;
    #1;
    n_checks++;
    if ({stallF, stallE, flushE} !== 3'b110) begin
      n_fail++; $display("FAIL div_no_flush: got %b expected 110", {stallF, stallE, flushE});
    end
    next_cycle();
    clear_inputs();
    divE = 1;
    repeat (4) next_cycle();
    divE = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid_div();
    clear_inputs();
    divE = 1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    regwriteM = 1; writeregM = 5; rsE = 5;
    @(negedge clk);
    n_checks++;
    if ({stallF, stallD, stallE, flushE, forwardaE, divbusy, divdoneE} !== 8'b0) begin
      n_fail++;
      $display("FAIL rst_mid_busy: got %b expected 00000000",
               {stallF, stallD, stallE, flushE, forwardaE, divbusy, divdoneE});
    end
    next_cycle();
    rst = 1'b0; divE = 0; regwriteM = 0;
    @(negedge clk);
    n_checks++;
    if ({divbusy, stallE, divdoneE} !== 3'b000) begin
      n_fail++; $display("FAIL rst_abandon: got %b expected 000", {divbusy, stallE, divdoneE});
    end
    next_cycle();
    divE = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({stallE, divdoneE} !== ((c <= 4) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rediv_cycle%0d: got %b expected %b", c, {stallE, divdoneE}, ((c <= 4) ? 2'b10 : 2'b01));
      end
      next_cycle();
    end
    divE = 0;
    next_cycle();
  endtask

  task automatic test_stallcnt();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stallcnt !== 32'd0) begin
      n_fail++; $display("FAIL cnt_after_reset: got %0d expected 0", stallcnt);
    end
    next_cycle();
    memtoregE = 1; rtE = 8; rsD = 8;
    repeat (3) next_cycle();
    clear_inputs();
    divE = 1;
    repeat (4) next_cycle();
    divE = 0;
    @(negedge clk);
    n_checks++;
    if (stallcnt !== EXP_CNT) begin
      n_fail++; $display("FAIL cnt_total: got %0d expected %0d", stallcnt, EXP_CNT);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (stallcnt !== EXP_CNT) begin
      n_fail++; $display("FAIL cnt_hold: got %0d expected %0d", stallcnt, EXP_CNT);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_divider();
    test_reset_mid_div();
    test_stallcnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
